// File: rtl/qpsk_dibit_serializer.sv
`timescale 1ns/1ps
// qpsk_dibit_serializer
//   Splits DIN_W-bit words from a valid/ready/last stream into 2-bit symbols
//   for the QPSK mapper. One dibit per clock with no bubbles between words
//   while out_ready is high. Frame boundaries pass through on dout_last, and
//   sym_cnt counts dibits transferred in the frame in progress.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   s_data     input word
//   s_valid    s_data/s_last valid
//   s_last     word is the final word of a frame
//   s_ready    word accepted this cycle
//   dout       current dibit (mapper din)
//   dout_valid dout valid
//   dout_last  final dibit of a frame
//   out_ready  downstream accepts a dibit this cycle
//   sym_cnt    dibits transferred so far in the current frame
module qpsk_dibit_serializer #(
  parameter int DIN_W     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIN_W-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [1:0]       dout,
  output logic             dout_valid,
  output logic             dout_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sym_cnt
);

  localparam int NSYM  = DIN_W / 2;
  localparam int REM_W = $clog2(NSYM + 1);
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(NSYM);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  typedef enum logic {
    EMPTY,
    BUSY
  } state_t;

  state_t           state;
  logic [DIN_W-1:0] sh, sh_nxt;
  logic [REM_W-1:0] rem, rem_nxt;
  logic             lst, lst_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load, xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      rem <= '0;
      lst <= 1'b0;
      cnt <= '0;
    end else begin
      sh  <= sh_nxt;
      rem <= rem_nxt;
      lst <= lst_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    // The state is fully encoded by rem; no separate state register is kept.
    state      = (rem == '0) ? EMPTY : BUSY;
    dout_valid = (state == BUSY);
    dout_last  = lst && (rem == REM_ONE);
    dout       = MSB_FIRST ? sh[DIN_W-1 -: 2] : sh[1:0];
    // Accepting while the final dibit leaves keeps the output gap-free.
    s_ready    = (state == EMPTY) || ((rem == REM_ONE) && out_ready);
    load       = s_valid && s_ready;
    xfer       = dout_valid && out_ready;

    sh_nxt  = sh;
    rem_nxt = rem;
    lst_nxt = lst;
    cnt_nxt = cnt;

    if (load) begin
      sh_nxt  = s_data;
      rem_nxt = REM_FULL;
      lst_nxt = s_last;
    end else if (xfer) begin
      rem_nxt = rem - REM_ONE;
      sh_nxt  = MSB_FIRST ? (sh << 2) : (sh >> 2);
    end

    if (xfer) begin
      cnt_nxt = dout_last ? '0 : cnt + CNT_W'(1);
    end
  end

  assign sym_cnt = cnt;

endmodule

// File: tb/tb_qpsk_dibit_serializer.sv
`timescale 1ns/1ps
// Bench for qpsk_dibit_serializer: three instances share one input stream
// (MSB-first, LSB-first, and MSB-first with a 4-bit symbol counter).
module tb_qpsk_dibit_serializer;

  localparam int DW   = 8;
  localparam int NSYM = DW / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid, s_last, out_ready;

  logic        m_sready, m_dv, m_dl;
  logic [1:0]  m_dout;
  logic [15:0] m_cnt;
  logic        l_sready, l_dv, l_dl;
  logic [1:0]  l_dout;
  logic [15:0] l_cnt;
  logic        c_sready, c_dv, c_dl;
  logic [1:0]  c_dout;
  logic [3:0]  c_cnt;

  qpsk_dibit_serializer #(.DIN_W(DW), .MSB_FIRST(1'b1), .CNT_W(16)) u_msb (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(m_sready), .dout(m_dout), .dout_valid(m_dv),
    .dout_last(m_dl), .out_ready(out_ready), .sym_cnt(m_cnt));

  qpsk_dibit_serializer #(.DIN_W(DW), .MSB_FIRST(1'b0), .CNT_W(16)) u_lsb (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(l_sready), .dout(l_dout), .dout_valid(l_dv),
    .dout_last(l_dl), .out_ready(out_ready), .sym_cnt(l_cnt));

  qpsk_dibit_serializer #(.DIN_W(DW), .MSB_FIRST(1'b1), .CNT_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(c_sready), .dout(c_dout), .dout_valid(c_dv),
    .dout_last(c_dl), .out_ready(out_ready), .sym_cnt(c_cnt));

  int errors = 0;
  int checks = 0;

  // Expected LSB-first dibits: {last, dibit}
  logic [2:0] sbq[$];

  typedef struct {
    logic [7:0] d;
    logic       v, l, r;
    logic [1:0] ed;
    logic       ev, el, es;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic l,
                              input logic r, input logic [1:0] ed, input logic ev,
                              input logic el, input logic es, input int ec);
    vec_t t;
    t.d = d; t.v = v; t.l = l; t.r = r;
    t.ed = ed; t.ev = ev; t.el = el; t.es = es; t.ec = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called once per cycle after inputs settle, before the rising edge.
  task automatic sb_cycle();
    logic [2:0] e;
    if (l_dv && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lsb_sb_unexpected: got dibit %0h expected none", l_dout);
      end else begin
        e = sbq.pop_front();
        chk("lsb_dout", 32'(l_dout), 32'(e[1:0]));
        chk("lsb_last", 32'(l_dl), 32'(e[2]));
      end
    end
    if (s_valid && l_sready) begin
      for (int i = 0; i < NSYM; i++)
        sbq.push_back({(s_last && (i == NSYM - 1)), s_data[2*i +: 2]});
    end
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic l, input logic r);
    @(negedge clk);
    s_data = d; s_valid = v; s_last = l; out_ready = r;
    #1;
    sb_cycle();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dv"},     32'(m_dv),     32'd0);
    chk({tag, "_dout"},   32'(m_dout),   32'd0);
    chk({tag, "_last"},   32'(m_dl),     32'd0);
    chk({tag, "_sready"}, 32'(m_sready), 32'd1);
    chk({tag, "_cnt"},    32'(m_cnt),    32'd0);
    chk({tag, "_c4cnt"},  32'(c_cnt),    32'd0);
  endtask

  logic [7:0] wrap_words [5];

  initial begin
    vec_t tv;
    int   widx;
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; out_ready = 1'b1;

    // Power-on reset
    #12;
    chk_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-word asynchronous reset at rem=2
    step(8'hB4, 1'b1, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("mid_dout",   32'(m_dout),   32'h1);
    chk("mid_dv",     32'(m_dv),     32'd1);
    chk("mid_cnt",    32'(m_cnt),    32'd2);
    chk("mid_sready", 32'(m_sready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("arst");
    chk("arst_lsb_dv", 32'(l_dv), 32'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single word, back-to-back frame, backpressure (MSB-first view)
    //          data   v     l     r     dout  v     last  srdy  cnt
    tbl.push_back(mk(8'hB4, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 2));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 3));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 0));
    tbl.push_back(mk(8'h1B, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 0));
    tbl.push_back(mk(8'hE4, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(8'hE4, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(8'hE4, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2));
    tbl.push_back(mk(8'hE4, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 3));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 4));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 6));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 7));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 0));
    tbl.push_back(mk(8'hC6, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 2));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 3));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 0));

    foreach (tbl[i]) begin
      tv = tbl[i];
      step(tv.d, tv.v, tv.l, tv.r);
      if (tv.ev) chk($sformatf("v%0d_dout", i), 32'(m_dout), 32'(tv.ed));
      chk($sformatf("v%0d_dv", i),     32'(m_dv),     32'(tv.ev));
      chk($sformatf("v%0d_last", i),   32'(m_dl),     32'(tv.el));
      chk($sformatf("v%0d_sready", i), 32'(m_sready), 32'(tv.es));
      chk($sformatf("v%0d_cnt", i),    32'(m_cnt),    32'(tv.ec));
      chk($sformatf("v%0d_c4cnt", i),  32'(c_cnt),    32'(tv.ec % 16));
      chk($sformatf("v%0d_lsb_dv", i), 32'(l_dv),     32'(tv.ev));
      chk($sformatf("v%0d_lsb_sr", i), 32'(l_sready), 32'(tv.es));
    end

    // Counter wrap: 5 back-to-back words (20 dibits), no s_last
    wrap_words[0] = 8'hA5; wrap_words[1] = 8'h3C; wrap_words[2] = 8'h0F;
    wrap_words[3] = 8'hF0; wrap_words[4] = 8'h99;
    for (int c = 0; c <= 21; c++) begin
      widx = (c == 0) ? 0 : (c - 1) / NSYM + 1;
      if (widx <= 4) step(wrap_words[widx], 1'b1, 1'b0, 1'b1);
      else           step(8'h00, 1'b0, 1'b0, 1'b1);
      chk($sformatf("wrap%0d_c4cnt", c), 32'(c_cnt), 32'(((c == 0) ? 0 : c - 1) % 16));
      chk($sformatf("wrap%0d_cnt", c),   32'(m_cnt), 32'((c == 0) ? 0 : c - 1));
      chk($sformatf("wrap%0d_dv", c),    32'(c_dv),  32'((c >= 1 && c <= 20) ? 1 : 0));
    end

    chk("lsb_sb_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
